data_memory_responder: RTL and testbench



---
 rtl/data_memory_responder_if.sv | 23 ++
 rtl/data_memory_responder.sv | 114 +++++++++++
 tb/tb_data_memory_responder.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_responder_if.sv
// Block-transfer bus between the data cache controller (master) and the
// memory responder (slave).
interface data_memory_responder_if #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128
);
  logic                   mem_Read;
  logic                   mem_Write;
  logic [ADDR_WIDTH-1:0]  mem_Address;
  logic [BLOCK_WIDTH-1:0] mem_Writedata;
  logic [BLOCK_WIDTH-1:0] mem_Readdata;
  logic                   mem_Busywait;

  modport master (
    output mem_Read, mem_Write, mem_Address, mem_Writedata,
    input  mem_Readdata, mem_Busywait
  );

  modport slave (
    input  mem_Read, mem_Write, mem_Address, mem_Writedata,
    output mem_Readdata, mem_Busywait
  );
endinterface

// File: rtl/data_memory_responder.sv
// Memory-side block responder: fixed-latency busywait, then a write to or a read from storage.
// Define DMEM_ERROR_FLAG_EN to add mem_Error (conflicting request or out-of-range address).
module data_memory_responder #(
  parameter int ADDR_WIDTH  = 28,
  parameter int BLOCK_WIDTH = 128,
  parameter int DEPTH_LOG2  = 8,
  parameter int LATENCY     = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  data_memory_responder_if.slave  bus
`ifdef DMEM_ERROR_FLAG_EN
  ,
  output logic                    mem_Error
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                 state, state_nx;
  logic [3:0]             counter;
  logic                   lat_read, lat_write;
  logic [DEPTH_LOG2-1:0]  lat_index;
  logic [BLOCK_WIDTH-1:0] lat_data;
  logic [BLOCK_WIDTH-1:0] readdata;
  logic                   busy;
  logic                   request;

  logic [BLOCK_WIDTH-1:0] storage [2**DEPTH_LOG2];

  assign request = bus.mem_Read | bus.mem_Write;
  assign bus.mem_Readdata = readdata;
  assign bus.mem_Busywait = busy;

`ifdef DMEM_ERROR_FLAG_EN
  logic lat_alias;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      lat_alias <= 1'b0;
    else if (state == IDLE && request)
      lat_alias <= |bus.mem_Address[ADDR_WIDTH-1:DEPTH_LOG2];
  end

  assign mem_Error = (state == DONE) && ((lat_read && lat_write) || lat_alias);
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      counter   <= 4'd0;
      lat_read  <= 1'b0;
      lat_write <= 1'b0;
      lat_index <= '0;
      lat_data  <= '0;
      readdata  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (request) begin
            lat_read  <= bus.mem_Read;
            lat_write <= bus.mem_Write;
            lat_index <= bus.mem_Address[DEPTH_LOG2-1:0];
            lat_data  <= bus.mem_Writedata;
            counter   <= 4'(LATENCY - 1);
          end
        end
        BUSY: begin
          if (counter == 4'd0) begin
            // write wins a read/write conflict, so no read data is returned then
            if (lat_read && !lat_write)
              readdata <= storage[lat_index];
          end else begin
            counter <= counter - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately left out of reset; the FSM is forced to IDLE so
  // an in-flight write never lands.
  always_ff @(posedge clock) begin
    if (state == BUSY && counter == 4'd0 && lat_write)
      storage[lat_index] <= lat_data;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        busy = request;
        if (request)
          state_nx = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (counter == 4'd0)
          state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (!reset)
      busy = 1'b0;
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder; mem_Error checks are built only
// when DMEM_ERROR_FLAG_EN is defined.
module tb_data_memory_responder;
  localparam int LAT = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_memory_responder_if bus_if ();
`ifdef DMEM_ERROR_FLAG_EN
  logic mem_error;
`endif

  data_memory_responder #(
    .ADDR_WIDTH(28), .BLOCK_WIDTH(128), .DEPTH_LOG2(8), .LATENCY(LAT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
`ifdef DMEM_ERROR_FLAG_EN
    ,
    .mem_Error (mem_error)
`endif
  );

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] ONES  = {32{4'h1}};
  localparam logic [127:0] THREE = {32{4'h3}};
  localparam logic [127:0] AAAA  = {32{4'hA}};
  localparam logic [127:0] FIVES = {32{4'h5}};
  localparam logic [127:0] DDDD  = {32{4'hD}};
  localparam logic [127:0] SEVEN = {32{4'h7}};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic rd, input logic wr, input logic [27:0] a, input logic [127:0] d);
    bus_if.mem_Read      = rd;
    bus_if.mem_Write     = wr;
    bus_if.mem_Address   = a;
    bus_if.mem_Writedata = d;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Counts edges until busywait is seen low; bounded so a stuck DUT still ends.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      edges++;
      if (!bus_if.mem_Busywait) break;
    end
  endtask

  // Request issued after an edge; E0 plus LATENCY edges until busy drops.
  // Leaves the bench in the DONE cycle with requests released.
  task automatic do_access(input string tag, input logic rd, input logic wr,
                           input logic [27:0] a, input logic [127:0] d);
    int n;
    set_req(rd, wr, a, d);
    #1;
    check({tag, "_busy_imm"}, 128'(bus_if.mem_Busywait), 128'(1));
    wait_done(n);
    check({tag, "_latency"}, 128'(n), 128'(LAT + 1));
    set_req(1'b0, 1'b0, 28'h0, 128'h0);
    #1;
    check({tag, "_done_low"}, 128'(bus_if.mem_Busywait), 128'(0));
  endtask

  initial begin
    int n;
    set_req(1'b0, 1'b0, 28'h0, 128'h0);

    #3 reset = 1'b0;
    #1;
    check("rst_busy", 128'(bus_if.mem_Busywait), 128'(0));
    check("rst_rdata", bus_if.mem_Readdata, 128'h0);
    #8 reset = 1'b1;
    step();

    do_access("wr5", 1'b0, 1'b1, 28'h0000005, ONES);
    step();
    check("wr5_idle", 128'(bus_if.mem_Busywait), 128'(0));

    do_access("rd5", 1'b1, 1'b0, 28'h0000005, 128'h0);
    check("rd5_data", bus_if.mem_Readdata, ONES);
`ifdef DMEM_ERROR_FLAG_EN
    check("rd5_err", 128'(mem_error), 128'(0));
`endif
    step();
    check("rd5_hold", bus_if.mem_Readdata, ONES);

    do_access("wr3", 1'b0, 1'b1, 28'h0000003, THREE);
    step();

    // write-back held until busy low, then fill issued in the DONE cycle
    set_req(1'b0, 1'b1, 28'h0000007, AAAA);
    #1;
    wait_done(n);
    check("b2b_wr_lat", 128'(n), 128'(LAT + 1));
    set_req(1'b1, 1'b0, 28'h0000003, 128'h0);
    #1;
    check("b2b_gap", 128'(bus_if.mem_Busywait), 128'(0));
    step();
    check("b2b_rd_busy", 128'(bus_if.mem_Busywait), 128'(1));
    wait_done(n);
    check("b2b_rd_lat", 128'(n), 128'(LAT + 1));
    check("b2b_rd_data", bus_if.mem_Readdata, THREE);
    set_req(1'b0, 1'b0, 28'h0, 128'h0);
    step();
    do_access("rd7", 1'b1, 1'b0, 28'h0000007, 128'h0);
    check("rd7_data", bus_if.mem_Readdata, AAAA);
    step();

    // write held for two cycles only
    set_req(1'b0, 1'b1, 28'h0000009, FIVES);
    step();
    step();
    set_req(1'b0, 1'b0, 28'h0, 128'h0);
    #1;
    check("drop_busy", 128'(bus_if.mem_Busywait), 128'(1));
    wait_done(n);
    check("drop_lat", 128'(n), 128'(LAT - 1));
    step();
    do_access("rd9", 1'b1, 1'b0, 28'h0000009, 128'h0);
    check("rd9_data", bus_if.mem_Readdata, FIVES);
    step();

    // reset during the second cycle of a write
    set_req(1'b0, 1'b1, 28'h0000009, DDDD);
    step();
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 128'(bus_if.mem_Busywait), 128'(0));
    check("mid_rst_rdata", bus_if.mem_Readdata, 128'h0);
    set_req(1'b0, 1'b0, 28'h0, 128'h0);
    @(negedge clock);
    reset = 1'b1;
    step();
    check("mid_rst_idle", 128'(bus_if.mem_Busywait), 128'(0));
    do_access("rd9b", 1'b1, 1'b0, 28'h0000009, 128'h0);
    check("rd9b_old", bus_if.mem_Readdata, FIVES);
    step();

    // read+write conflict at an aliased address
    set_req(1'b1, 1'b1, 28'h0000105, SEVEN);
    #1;
`ifdef DMEM_ERROR_FLAG_EN
    check("cf_err_idle", 128'(mem_error), 128'(0));
`endif
    check("cf_busy_imm", 128'(bus_if.mem_Busywait), 128'(1));
    step();
`ifdef DMEM_ERROR_FLAG_EN
    check("cf_err_busy", 128'(mem_error), 128'(0));
`endif
    wait_done(n);
    check("cf_lat", 128'(n), 128'(LAT));
    check("cf_no_rdata", bus_if.mem_Readdata, FIVES);
`ifdef DMEM_ERROR_FLAG_EN
    check("cf_err_done", 128'(mem_error), 128'(1));
`endif
    set_req(1'b0, 1'b0, 28'h0, 128'h0);
    step();
`ifdef DMEM_ERROR_FLAG_EN
    check("cf_err_after", 128'(mem_error), 128'(0));
`endif
    do_access("rd5b", 1'b1, 1'b0, 28'h0000005, 128'h0);
    check("alias_data", bus_if.mem_Readdata, SEVEN);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
